// File: rtl/expr_tokenizer_if.sv
// Handshake bundle between the host receive path and the expression tokenizer:
// ASCII bytes in, operator and operand results out.
interface expr_tokenizer_if #(
    parameter int WIDTH = 16
);
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic [7:0]       op;
    logic             op_ready;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             operands_valid;
    logic             busy;
    logic             err;

    modport master (
        output rx_data, rx_valid,
        input  op, op_ready, operand_a, operand_b, operands_valid, busy, err
    );

    modport slave (
        input  rx_data, rx_valid,
        output op, op_ready, operand_a, operand_b, operands_valid, busy, err
    );
endinterface

// File: rtl/expr_tokenizer.sv
// Parses "<A><op><B><term>" ASCII lines into binary operands and an operator byte.
// Define NEG_OPERAND_EN to accept a leading '-' sign on each operand (two's complement output).
module expr_tokenizer #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 5
) (
    input logic             clk,
    input logic             reset,
    expr_tokenizer_if.slave bus
);
    localparam int EW = WIDTH + 4;
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [EW-1:0] ONE = EW'(1);
`ifdef NEG_OPERAND_EN
    localparam logic [EW-1:0] LIM_POS = (ONE << (WIDTH - 1)) - ONE;
    localparam logic [EW-1:0] LIM_NEG = ONE << (WIDTH - 1);
    localparam logic [7:0]    CH_MINUS = 8'h2D;
`else
    localparam logic [EW-1:0] LIM_U = (ONE << WIDTH) - ONE;
`endif

    typedef enum logic [1:0] {S_A_START, S_A_DIG, S_B_START, S_B_DIG} state_t;
    typedef enum logic [2:0] {C_DIGIT, C_OP, C_SPACE, C_TERM, C_ILLEGAL} class_t;
    typedef enum logic [2:0] {
        ACT_NONE, ACT_FIRST, ACT_ACCUM, ACT_LATCH_A, ACT_DONE, ACT_ERR, ACT_SIGN
    } action_t;

    state_t           state;
    state_t           state_next;
    class_t           byte_class;
    action_t          action;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_hold;
    logic [WIDTH-1:0] value;
    logic [EW-1:0]    acc_ext;
    logic [EW-1:0]    limit;
    logic [3:0]       digit;
    logic             accum_bad;
    logic [7:0]       op_q;
    logic             op_ready_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             ov_q;
    logic             err_q;
`ifdef NEG_OPERAND_EN
    logic             neg;
`endif

    always_comb begin
        byte_class = C_ILLEGAL;
        if (bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39) begin
            byte_class = C_DIGIT;
        end else begin
            case (bus.rx_data)
                8'h2B, 8'h2D, 8'h2A, 8'h2F: byte_class = C_OP;
                8'h20:                      byte_class = C_SPACE;
                8'h3D, 8'h0A, 8'h0D:        byte_class = C_TERM;
                default:                    byte_class = C_ILLEGAL;
            endcase
        end
    end

    // acc*10 + d done as shifts in a widened word so overflow is visible before truncation
    assign digit     = bus.rx_data[3:0];
    assign acc_ext   = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) + {{(EW-4){1'b0}}, digit};
    assign accum_bad = (acc_ext > limit) || (cnt == CW'(MAX_DIGITS));

`ifdef NEG_OPERAND_EN
    assign limit = neg ? LIM_NEG : LIM_POS;
    assign value = neg ? (~acc + WIDTH'(1)) : acc;
`else
    assign limit = LIM_U;
    assign value = acc;
`endif

    always_comb begin
        state_next = state;
        action     = ACT_NONE;
        if (bus.rx_valid && byte_class != C_SPACE) begin
            case (state)
                S_A_START, S_B_START: begin
                    if (byte_class == C_DIGIT) begin
                        action     = ACT_FIRST;
                        state_next = (state == S_A_START) ? S_A_DIG : S_B_DIG;
`ifdef NEG_OPERAND_EN
                    end else if (bus.rx_data == CH_MINUS && !neg) begin
                        action = ACT_SIGN;
                    end else if (state == S_A_START && byte_class == C_TERM && !neg) begin
                        action = ACT_NONE;
`else
                    end else if (state == S_A_START && byte_class == C_TERM) begin
                        action = ACT_NONE;
`endif
                    end else begin
                        action     = ACT_ERR;
                        state_next = S_A_START;
                    end
                end
                S_A_DIG, S_B_DIG: begin
                    if (byte_class == C_DIGIT) begin
                        if (accum_bad) begin
                            action     = ACT_ERR;
                            state_next = S_A_START;
                        end else begin
                            action = ACT_ACCUM;
                        end
                    end else if (state == S_A_DIG && byte_class == C_OP) begin
                        action     = ACT_LATCH_A;
                        state_next = S_B_START;
                    end else if (state == S_B_DIG && byte_class == C_TERM) begin
                        action     = ACT_DONE;
                        state_next = S_A_START;
                    end else begin
                        action     = ACT_ERR;
                        state_next = S_A_START;
                    end
                end
                default: begin
                    action     = ACT_ERR;
                    state_next = S_A_START;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_A_START;
            acc        <= '0;
            cnt        <= '0;
            a_hold     <= '0;
            op_q       <= '0;
            op_ready_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            ov_q       <= 1'b0;
            err_q      <= 1'b0;
`ifdef NEG_OPERAND_EN
            neg        <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            op_ready_q <= 1'b0;
            ov_q       <= 1'b0;
            err_q      <= 1'b0;
            case (action)
                ACT_FIRST: begin
                    acc <= WIDTH'(digit);
                    cnt <= CW'(1);
                end
                ACT_ACCUM: begin
                    acc <= acc_ext[WIDTH-1:0];
                    cnt <= cnt + CW'(1);
                end
                ACT_LATCH_A: begin
                    a_hold     <= value;
                    op_q       <= bus.rx_data;
                    op_ready_q <= 1'b1;
                    acc        <= '0;
                    cnt        <= '0;
`ifdef NEG_OPERAND_EN
                    neg        <= 1'b0;
`endif
                end
                ACT_DONE: begin
                    a_q  <= a_hold;
                    b_q  <= value;
                    ov_q <= 1'b1;
                    acc  <= '0;
                    cnt  <= '0;
`ifdef NEG_OPERAND_EN
                    neg  <= 1'b0;
`endif
                end
                ACT_ERR: begin
                    err_q <= 1'b1;
                    acc   <= '0;
                    cnt   <= '0;
`ifdef NEG_OPERAND_EN
                    neg   <= 1'b0;
`endif
                end
`ifdef NEG_OPERAND_EN
                ACT_SIGN: neg <= 1'b1;
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.busy           = (state != S_A_START);
        bus.op             = op_q;
        bus.op_ready       = op_ready_q;
        bus.operand_a      = a_q;
        bus.operand_b      = b_q;
        bus.operands_valid = ov_q;
        bus.err            = err_q;
    end
endmodule
